// File: rtl/iq_avg_pkg.sv
// Shared constants, length-field type and accumulator sizing for the IQ block averager.
package iq_avg_pkg;

  localparam int NBITS_D    = 16;
  localparam int MAX_LOG2_D = 4;
  localparam int NCH_D      = 2;

  typedef logic [$clog2(MAX_LOG2_D+1)-1:0] len_t;

  // Summing 2^maxlog samples grows the word by maxlog bits.
  function automatic int accw(input int nbits, input int maxlog);
    return nbits + maxlog;
  endfunction

endpackage

// File: rtl/iq_block_averager_avg_channel.sv
// One channel of the block averager: signed accumulator plus shift (and optional
// round-half-up when AVG_ROUND_EN is defined) producing the block mean.
module avg_channel
  import iq_avg_pkg::*;
#(
  parameter int NBITS    = NBITS_D,
  parameter int MAX_LOG2 = MAX_LOG2_D,
  parameter int LW       = $clog2(MAX_LOG2+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    load,
  input  logic                    add,
  input  logic signed [NBITS-1:0] sample,
  input  logic        [LW-1:0]    len,
  output logic        [NBITS-1:0] result
);

  localparam int ACCW = accw(NBITS, MAX_LOG2);

  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] sample_x;
  logic signed [ACCW-1:0] sum;

  assign sample_x = {{MAX_LOG2{sample[NBITS-1]}}, sample};

  // NOTE: the accumulator is plain state, so it is reset with the rest of the
  // datapath; non-blocking assignments keep the update order-independent.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q <= '0;
    end else if (load) begin
      acc_q <= sample_x;
    end else if (add) begin
      acc_q <= acc_q + sample_x;
    end
  end

  // The closing sample is folded in combinationally so the mean is ready on that edge.
  assign sum = start ? sample_x : acc_q + sample_x;

`ifdef AVG_ROUND_EN
  logic        [ACCW:0] bias;
  logic signed [ACCW:0] sum_r;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    bias = '0;
    if (len != '0) begin
      bias = (ACCW+1)'(1) << (len - LW'(1));
    end
    sum_r  = {sum[ACCW-1], sum} + bias;
    result = NBITS'(sum_r >>> len);
  end
`else
  always_comb begin
    result = NBITS'(sum >>> len);
  end
`endif

endmodule

// File: rtl/iq_block_averager.sv
// Multi-channel IQ block averager: mean of 2^L samples per channel with flush,
// valid/ready output and overrun counting. Define AVG_ROUND_EN for round-half-up.
module iq_block_averager
  import iq_avg_pkg::*;
#(
  parameter int NBITS    = NBITS_D,
  parameter int MAX_LOG2 = MAX_LOG2_D,
  parameter int NCH      = NCH_D,
  parameter int OVR_BITS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [NCH*NBITS-1:0]             in_data,
  input  logic [$clog2(MAX_LOG2+1)-1:0]    log2_len,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NCH*NBITS-1:0]             out_data,
  output logic [MAX_LOG2-1:0]              block_cnt,
  output logic [OVR_BITS-1:0]              overrun_cnt
);

  localparam int LW = $clog2(MAX_LOG2+1);

  logic [MAX_LOG2-1:0]  cnt_q;
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        eff_len;
  logic [MAX_LOG2:0]    term;
  logic                 accept;
  logic                 start;
  logic                 last;
  logic [NCH*NBITS-1:0] result;

  assign accept = in_valid && !flush;
  assign start  = (cnt_q == '0);

  // The length is sampled only at block start; mid-block changes wait for the next block.
  always_comb begin
    eff_len = len_q;
    if (start) begin
      eff_len = (log2_len > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : log2_len;
    end
    term = ((MAX_LOG2+1)'(1) << eff_len) - (MAX_LOG2+1)'(1);
  end

  assign last = accept && ({1'b0, cnt_q} == term);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    avg_channel #(
      .NBITS    (NBITS),
      .MAX_LOG2 (MAX_LOG2),
      .LW       (LW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .clear  (flush),
      .start  (start),
      .load   (accept && start),
      .add    (accept && !start),
      .sample (in_data[k*NBITS +: NBITS]),
      .len    (eff_len),
      .result (result[k*NBITS +: NBITS])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      len_q       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      overrun_cnt <= '0;
    end else begin
      if (flush) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= last ? '0 : cnt_q + MAX_LOG2'(1);
        if (start) begin
          len_q <= eff_len;
        end
      end

      // A landing result wins over a handshake; only an unaccepted result counts as overrun.
      if (last) begin
        out_data  <= result;
        out_valid <= 1'b1;
        if (out_valid && !out_ready && (overrun_cnt != '1)) begin
          overrun_cnt <= overrun_cnt + OVR_BITS'(1);
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign block_cnt = cnt_q;

endmodule
